// File: rtl/mc_ctrl.sv
// mc_ctrl -- multicycle control unit for the ARM-subset processor.
//
// Sequences each instruction through FETCH, DECODE and then the memory,
// data-processing or branch path, one state per clock. Holds the NZCV flag
// register and gates every instruction with a condition check against it.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-high reset
//   Cond       : instruction condition field [31:28]
//   Op         : instruction class [27:26]
//   Funct      : instruction bits [25:20] (I, cmd[3:0], S/L)
//   Rd         : destination register [15:12]
//   ALUFlags   : {N,Z,C,V} produced by the ALU this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite : datapath write enables
//   AdrSrc     : memory address select (0 PC, 1 ALUOut)
//   ALUSrcA    : 00 Rn, 01 PC, 10 ALUOut
//   ALUSrcB    : 00 Rm, 01 ExtImm, 10 constant 4
//   ResultSrc  : 00 ALUOut, 01 read data, 10 ALU result
//   ImmSrc     : immediate extension select, follows Op
//   RegSrc     : register-file read address selects
//   ALUControl : 00 ADD, 01 SUB, 10 AND, 11 ORR
//   Flags      : stored {N,Z,C,V}
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } ctrlState;

  ctrlState   state;
  ctrlState   nextState;
  logic       condEx;
  logic       cmdSupported;
  logic [1:0] aluDecoded;
  logic       inExec;
  logic       pcWriteRaw;
  logic       memWriteRaw;
  logic       regWriteRaw;
  logic       irWriteRaw;

  // Condition check: decides from the stored flags whether the instruction
  // currently in the IR is allowed to do anything at all. Code 1111 is the
  // "never" condition in this subset, so it falls through to the default.
  always_comb begin
    condEx = 1'b0;
    case (Cond)
      4'b0000: condEx = Flags[2];
      4'b0001: condEx = ~Flags[2];
      4'b0010: condEx = Flags[1];
      4'b0011: condEx = ~Flags[1];
      4'b0100: condEx = Flags[3];
      4'b0101: condEx = ~Flags[3];
      4'b0110: condEx = Flags[0];
      4'b0111: condEx = ~Flags[0];
      4'b1000: condEx = Flags[1] & ~Flags[2];
      4'b1001: condEx = ~Flags[1] | Flags[2];
      4'b1010: condEx = (Flags[3] == Flags[0]);
      4'b1011: condEx = (Flags[3] != Flags[0]);
      4'b1100: condEx = ~Flags[2] & (Flags[3] == Flags[0]);
      4'b1101: condEx = Flags[2] | (Flags[3] != Flags[0]);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  // Data-processing command decode. Unknown commands still run through the
  // EXEC/ALUWB states so cycle counts stay fixed, but they must not touch the
  // register file or the flags, so cmdSupported is used to squash those.
  always_comb begin
    aluDecoded   = 2'b00;
    cmdSupported = 1'b1;
    case (Funct[4:1])
      4'b0100: aluDecoded = 2'b00;
      4'b0010: aluDecoded = 2'b01;
      4'b0000: aluDecoded = 2'b10;
      4'b1100: aluDecoded = 2'b11;
      default: begin
        aluDecoded   = 2'b00;
        cmdSupported = 1'b0;
      end
    endcase
  end

  assign inExec = (state == EXECR) || (state == EXECI);

  // State register. Reset lands directly in FETCH so that the first edge
  // after release completes an instruction fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // Flag register. Loaded on the edge that leaves EXEC, so the flags become
  // visible from the ALUWB cycle on and therefore only to later instructions.
  // Logical ops keep the old carry and overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (inExec && Funct[0] && cmdSupported) begin
      Flags[3:2] <= ALUFlags[3:2];
      if (!aluDecoded[1]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Next-state and Moore output decode. Every output gets a neutral default
  // first; each state only lists what it actually drives. Write enables are
  // produced as raw values here and gated with reset further down.
  always_comb begin
    nextState   = state;
    pcWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    ALUControl  = 2'b00;
    case (state)
      FETCH: begin
        irWriteRaw = 1'b1;
        pcWriteRaw = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        nextState  = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (!condEx)          nextState = FETCH;
        else if (Op == 2'b01) nextState = MEMADR;
        else if (Op == 2'b00) nextState = Funct[5] ? EXECI : EXECR;
        else if (Op == 2'b10) nextState = BRANCH;
        else                  nextState = FETCH;
      end
      MEMADR: begin
        ALUSrcB   = 2'b01;
        nextState = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
        nextState = MEMWB;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
        pcWriteRaw  = (Rd == 4'hF);
        nextState   = FETCH;
      end
      MEMWR: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
        nextState   = FETCH;
      end
      EXECR: begin
        ALUControl = aluDecoded;
        nextState  = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = aluDecoded;
        nextState  = ALUWB;
      end
      ALUWB: begin
        regWriteRaw = cmdSupported;
        pcWriteRaw  = cmdSupported && (Rd == 4'hF);
        nextState   = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pcWriteRaw = 1'b1;
        nextState  = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  // While reset is held the state already reads FETCH, which would otherwise
  // raise IRWrite and PCWrite; all write enables are held low until release.
  assign PCWrite  = pcWriteRaw  & ~reset;
  assign MemWrite = memWriteRaw & ~reset;
  assign RegWrite = regWriteRaw & ~reset;
  assign IRWrite  = irWriteRaw  & ~reset;

  // Instruction-dependent selects that follow the IR rather than the state.
  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
//
// Each directed instruction is expanded by an instruction-level model into
// the list of cycles it must take and the control values each cycle must
// show. A compare process pops one expected cycle per clock and checks the
// DUT; literal expectations pin cycle counts and flag results.
module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] Flags;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       pcw, mw, rw, irw;
    logic       adr;
    logic [1:0] a, b, r, alu;
    logic [1:0] imm, rsel;
    logic [3:0] flg;
    logic       cAdr, cA, cB, cR, cAlu;
  } expCycle;

  expCycle    expQ[$];
  logic [3:0] mFlags;
  string      curName;
  int         compared;
  int         mismatched;

  // One comparison: counts it and reports a FAIL line when it disagrees.
  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Condition check from the ARM meanings, on the model's own flags.
  function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Builds one expected cycle; a negative select means "not checked here".
  function automatic expCycle mk(input logic pcw, input logic mw, input logic rw,
                                 input logic irw, input int adr, input int a,
                                 input int b, input int r, input int alu);
    expCycle e;
    e.pcw  = pcw;  e.mw = mw;  e.rw = rw;  e.irw = irw;
    e.cAdr = (adr >= 0); e.adr = adr[0];
    e.cA   = (a >= 0);   e.a   = a[1:0];
    e.cB   = (b >= 0);   e.b   = b[1:0];
    e.cR   = (r >= 0);   e.r   = r[1:0];
    e.cAlu = (alu >= 0); e.alu = alu[1:0];
    e.imm  = Op;
    e.rsel = {(Op == 2'b01), (Op == 2'b10)};
    e.flg  = mFlags;
    return e;
  endfunction

  // Drives one instruction (entered during its FETCH cycle), expands it into
  // expected cycles, and waits until every cycle has been compared.
  task automatic applyStimulus(input string name, input logic [3:0] c,
                               input logic [1:0] op, input logic [5:0] f,
                               input logic [3:0] rd, input logic [3:0] af,
                               input int expCycles);
    logic       sup;
    int         alu;
    int         guard;
    curName = name;
    Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
    expQ.push_back(mk(1, 0, 0, 1, 0, 1, 2, 2, 0));
    expQ.push_back(mk(0, 0, 0, 0, -1, 1, 2, 2, 0));
    if (condHolds(c, mFlags)) begin
      case (op)
        2'b01: begin
          expQ.push_back(mk(0, 0, 0, 0, -1, 0, 1, -1, 0));
          if (f[0]) begin
            expQ.push_back(mk(0, 0, 0, 0, 1, -1, -1, -1, -1));
            expQ.push_back(mk(rd == 4'd15, 0, 1, 0, -1, -1, -1, 1, -1));
          end else begin
            expQ.push_back(mk(0, 1, 0, 0, 1, -1, -1, -1, -1));
          end
        end
        2'b00: begin
          sup = 1'b1;
          case (f[4:1])
            4'd4:    alu = 0;
            4'd2:    alu = 1;
            4'd0:    alu = 2;
            4'd12:   alu = 3;
            default: begin alu = 0; sup = 1'b0; end
          endcase
          expQ.push_back(mk(0, 0, 0, 0, -1, 0, f[5] ? 1 : 0, -1, alu));
          if (f[0] && sup) begin
            mFlags[3:2] = af[3:2];
            if (alu < 2) mFlags[1:0] = af[1:0];
          end
          expQ.push_back(mk(sup && (rd == 4'd15), 0, sup, 0, -1, -1, -1, 0, -1));
        end
        2'b10: expQ.push_back(mk(1, 0, 0, 0, -1, 2, 1, 2, 0));
        default: ;
      endcase
    end
    checkOutput({name, ":cycles"}, 8'(expQ.size()), 8'(expCycles));
    guard = 0;
    while (expQ.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (expQ.size() > 0) begin
      checkOutput({name, ":timeout"}, 8'(expQ.size()), 8'd0);
      expQ.delete();
    end
    #1;
  endtask

  // Compare process: one expected cycle per clock, sampled mid-cycle.
  always @(negedge clk) begin
    expCycle e;
    if (!reset && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({curName, ":PCWrite"},  8'(PCWrite),  8'(e.pcw));
      checkOutput({curName, ":MemWrite"}, 8'(MemWrite), 8'(e.mw));
      checkOutput({curName, ":RegWrite"}, 8'(RegWrite), 8'(e.rw));
      checkOutput({curName, ":IRWrite"},  8'(IRWrite),  8'(e.irw));
      checkOutput({curName, ":ImmSrc"},   8'(ImmSrc),   8'(e.imm));
      checkOutput({curName, ":RegSrc"},   8'(RegSrc),   8'(e.rsel));
      checkOutput({curName, ":Flags"},    8'(Flags),    8'(e.flg));
      if (e.cAdr) checkOutput({curName, ":AdrSrc"},     8'(AdrSrc),     8'(e.adr));
      if (e.cA)   checkOutput({curName, ":ALUSrcA"},    8'(ALUSrcA),    8'(e.a));
      if (e.cB)   checkOutput({curName, ":ALUSrcB"},    8'(ALUSrcB),    8'(e.b));
      if (e.cR)   checkOutput({curName, ":ResultSrc"},  8'(ResultSrc),  8'(e.r));
      if (e.cAlu) checkOutput({curName, ":ALUControl"}, 8'(ALUControl), 8'(e.alu));
    end
  end

  // Directed program: reset, each instruction class, condition pass/fail,
  // PC destinations, an unsupported command, and reset mid-instruction.
  initial begin
    compared   = 0;
    mismatched = 0;
    mFlags     = 4'b0000;
    curName    = "init";
    reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    #2;
    checkOutput("rst:Flags",    8'(Flags),    8'h0);
    checkOutput("rst:IRWrite",  8'(IRWrite),  8'h0);
    checkOutput("rst:PCWrite",  8'(PCWrite),  8'h0);
    checkOutput("rst:ALUSrcA",  8'(ALUSrcA),  8'h1);
    checkOutput("rst:ALUSrcB",  8'(ALUSrcB),  8'h2);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("rel:IRWrite", 8'(IRWrite), 8'h1);

    applyStimulus("ADDS",    4'hE, 2'b00, 6'b001001, 4'd1,  4'b0110, 4);
    checkOutput("ADDS:FlagsLit", 8'(Flags), 8'b0110);
    applyStimulus("ANDS",    4'hE, 2'b00, 6'b000001, 4'd2,  4'b1011, 4);
    checkOutput("ANDS:FlagsLit", 8'(Flags), 8'b1010);
    applyStimulus("LDR",     4'hE, 2'b01, 6'b011001, 4'd3,  4'b0000, 5);
    applyStimulus("STR",     4'hE, 2'b01, 6'b011000, 4'd3,  4'b0000, 4);
    applyStimulus("BEQnt",   4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, 2);
    applyStimulus("SUBS",    4'hE, 2'b00, 6'b000101, 4'd4,  4'b0100, 4);
    checkOutput("SUBS:FlagsLit", 8'(Flags), 8'b0100);
    applyStimulus("BEQt",    4'h0, 2'b10, 6'b100000, 4'd0,  4'b0000, 3);
    applyStimulus("ADDpc",   4'hE, 2'b00, 6'b101000, 4'd15, 4'b1111, 4);
    applyStimulus("NV",      4'hF, 2'b00, 6'b001001, 4'd5,  4'b1111, 2);
    applyStimulus("Op11",    4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 2);
    applyStimulus("ORRS",    4'hE, 2'b00, 6'b011001, 4'd6,  4'b1101, 4);
    checkOutput("ORRS:FlagsLit", 8'(Flags), 8'b1100);
    applyStimulus("LDRLTpc", 4'hB, 2'b01, 6'b011001, 4'd15, 4'b0000, 5);
    applyStimulus("BADCMD",  4'hE, 2'b00, 6'b000111, 4'd2,  4'b0011, 4);
    checkOutput("BADCMD:FlagsLit", 8'(Flags), 8'b1100);

    // Reset during the EXECR cycle of a plain ADD.
    curName = "midRst";
    Cond = 4'hE; Op = 2'b00; Funct = 6'b001000; Rd = 4'd7; ALUFlags = 4'b1111;
    @(posedge clk);
    @(posedge clk); #2;
    checkOutput("midRst:inExecB", 8'(ALUSrcB), 8'h0);
    reset = 1'b1;
    #1;
    checkOutput("midRst:Flags",    8'(Flags),    8'h0);
    checkOutput("midRst:RegWrite", 8'(RegWrite), 8'h0);
    checkOutput("midRst:IRWrite",  8'(IRWrite),  8'h0);
    checkOutput("midRst:ALUSrcA",  8'(ALUSrcA),  8'h1);
    @(posedge clk); #1;
    checkOutput("midRst:PCWrite",  8'(PCWrite),  8'h0);
    checkOutput("midRst:Flags2",   8'(Flags),    8'h0);
    reset = 1'b0;
    mFlags = 4'b0000;
    #1;
    checkOutput("midRst:IRWriteRel", 8'(IRWrite), 8'h1);

    applyStimulus("ADDSNE",  4'h1, 2'b00, 6'b101001, 4'd8,  4'b1001, 4);
    checkOutput("ADDSNE:FlagsLit", 8'(Flags), 8'b1001);
    applyStimulus("tailNOP", 4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the ARM-subset processor. It sequences fetch, decode, execute, memory and writeback through a Moore state machine. It holds the NZCV flag register and gates every instruction with the condition-check logic, which evaluates the instruction's `Cond` field against the stored flags. It drives all datapath mux selects and write enables; the datapath feeds back `Op`, `Funct`, `Rd`, `Cond` and `ALUFlags`.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `Cond` in 4: instruction bits [31:28].
- `Op` in 2: instruction bits [27:26].
- `Funct` in 6: instruction bits [25:20]. Bit 5 is I, bits 4:1 are cmd, bit 0 is S/L.
- `Rd` in 4: instruction bits [15:12].
- `ALUFlags` in 4: {N,Z,C,V} from the ALU in the current cycle.
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite` out 1 each: write enables.
- `AdrSrc` out 1: 0 selects PC, 1 selects ALU result register.
- `ALUSrcA` out 2: 00 selects Rn, 01 selects PC, 10 selects ALUOut.
- `ALUSrcB` out 2: 00 selects Rm, 01 selects ExtImm, 10 selects constant 4.
- `ResultSrc` out 2: 00 selects ALUOut, 01 selects read data, 10 selects ALU result.
- `ImmSrc` out 2: equal to `Op`.
- `RegSrc` out 2: bit 0 = (Op==10), bit 1 = (Op==01). Combinational.
- `ALUControl` out 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `Flags` out 4: stored {N,Z,C,V}.

## Operation
- States are FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Outputs are Moore functions of state, except `ImmSrc`, `RegSrc` and ALU decode.
- FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD. Always goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD. CondEx is computed from `Cond` and `Flags`.
  - CondEx=0 → FETCH with no writes.
  - Otherwise Op=01 → MEMADR.
  - Op=00 with Funct[5]=0 → EXECR; with Funct[5]=1 → EXECI.
  - Op=10 → BRANCH.
  - Op=11 → FETCH as a NOP.
- CondEx table: 0000 EQ … 1101 LE follow the standard ARM meanings. 1110 → 1. 1111 → 0 (never executes).
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Goes to MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWR: AdrSrc=1, MemWrite=1 → FETCH.
- EXECR: ALUSrcA=00, ALUSrcB=00. EXECI: ALUSrcA=00, ALUSrcB=01. Both decode cmd and go to ALUWB.
- Cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR. Any other cmd gives ALUControl=00 and suppresses both RegWrite and flag update.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=1 → FETCH.
- Rd=15 in MEMWB or ALUWB also asserts PCWrite.
- Flag update happens on the edge leaving EXECR/EXECI when Funct[0]=1 and cmd is supported.
  - N and Z are always loaded from `ALUFlags`.
  - C and V are loaded only for ADD/SUB.

## Timing
- Reset: state=FETCH and Flags=0000 immediately. All write enables (PCWrite, MemWrite, RegWrite, IRWrite) are forced to 0 while reset is high. Mux selects show FETCH values.
- Reset asserted mid-instruction aborts it and suppresses all writes. After release, the first edge completes FETCH.
- Cycles per instruction: data-processing 4, LDR 5, STR 4, branch 3, condition-failed or Op=11 2.
- Flags written in an instruction's EXEC cycle are visible to the next instruction's DECODE. They are never visible to the same instruction.
- Exactly one state per cycle; no stalls; no handshake with memory.

## Test plan
- Reset mid-instruction: assert reset during an EXECR cycle → Flags=0000 and state FETCH immediately; no write enable high during reset; IRWrite=1 on the first cycle after release.
- Data-processing with flags: ADDS (Op=00, Funct=001001) with ALUFlags=0110 → 4 cycles; RegWrite only in ALUWB; Flags=0110 afterwards.
- Logical op with flags: ANDS (Funct=000001) with ALUFlags=1011 and prior Flags=0110 → Flags=1010 (C,V retained).
- Load and store: LDR (Op=01, Funct[0]=1) → 5 cycles, AdrSrc=1 in MEMRD, RegWrite with ResultSrc=01 in MEMWB. STR → MemWrite=1 only in MEMWR.
- Conditional branch: BEQ with Flags Z=0 → DECODE→FETCH, 2 cycles, PCWrite only in FETCH. Same branch with Z=1 → BRANCH state with PCWrite=1.
- PC destination and never-execute: ADD with Rd=15 → PCWrite and RegWrite both 1 in ALUWB. Cond=1111 → skipped, no writes.
